// File: rtl/deserial_vec_if.sv
// Serial sample lane into deserial_vec and the parallel vector it produces.
interface deserial_vec_if #(
  parameter int unsigned CORE   = 4,
  parameter int unsigned DWIDTH = 16
);
  logic                     deserial_start;
  logic                     in_valid;
  logic signed [DWIDTH-1:0] in_data;
  logic                     flush;
  logic signed [DWIDTH-1:0] out_data [CORE];
  logic                     out_valid;
  logic                     busy;

  modport master (
    output deserial_start, in_valid, in_data, flush,
    input  out_data, out_valid, busy
  );

  modport slave (
    input  deserial_start, in_valid, in_data, flush,
    output out_data, out_valid, busy
  );
endinterface

// File: rtl/deserial_vec.sv
// Collects CORE serial samples (lane 0 first) into a registered parallel vector.
// Optional early frame termination via flush when DESERIAL_FLUSH_EN is defined.
module deserial_vec #(
  parameter int unsigned CORE   = 4,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned LWIDTH = 3
) (
  input  logic          clk,
  input  logic          xrst,
  deserial_vec_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [LWIDTH-1:0]        cnt_q, cnt_d;
  logic signed [DWIDTH-1:0] buf_q [CORE];
  logic signed [DWIDTH-1:0] buf_d [CORE];
  logic signed [DWIDTH-1:0] out_q [CORE];
  logic signed [DWIDTH-1:0] out_d [CORE];
  logic signed [DWIDTH-1:0] merged [CORE];
  logic                     out_valid_q, out_valid_d;
  logic                     flush_c;

`ifdef DESERIAL_FLUSH_EN
  assign flush_c = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_c      = 1'b0;
`endif

  // Fill buffer with the current sample written at the current lane.
  always_comb begin
    for (int i = 0; i < int'(CORE); i++) begin
      merged[i] = buf_q[i];
      if (bus.in_valid && (LWIDTH'(i) == cnt_q)) merged[i] = bus.in_data;
    end
  end

  // Next-state: start has priority, then completion/flush, then plain accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (bus.deserial_start) begin
      state_d = FILL;
      cnt_d   = '0;
      for (int i = 0; i < int'(CORE); i++) buf_d[i] = '0;
      if (bus.in_valid) begin
        buf_d[0] = bus.in_data;
        cnt_d    = LWIDTH'(1);
      end
    end else if (state_q == FILL) begin
      if ((bus.in_valid && (cnt_q == LWIDTH'(CORE - 1))) || flush_c) begin
        out_d       = merged;
        out_valid_d = 1'b1;
        state_d     = IDLE;
        cnt_d       = '0;
      end else if (bus.in_valid) begin
        buf_d = merged;
        cnt_d = cnt_q + LWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(CORE); i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == FILL);
endmodule

// File: tb/tb_deserial_vec.sv
// Directed bench for deserial_vec with CORE=4, DWIDTH=16.
module tb_deserial_vec;
  logic clk;
  logic xrst;
  int   n_chk;
  int   n_fail;

  deserial_vec_if #(.CORE(4), .DWIDTH(16)) bus ();

  deserial_vec #(.CORE(4), .DWIDTH(16), .LWIDTH(3)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec();
    return {bus.out_data[3], bus.out_data[2], bus.out_data[1], bus.out_data[0]};
  endfunction

  task automatic cyc(input logic st, input logic vl, input logic signed [15:0] d,
                     input logic fl = 1'b0);
    bus.deserial_start = st;
    bus.in_valid       = vl;
    bus.in_data        = d;
    bus.flush          = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    xrst   = 1'b0;
    bus.deserial_start = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.flush          = 1'b0;
    #12;
    chk("reset_ov",   64'(bus.out_valid), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_data", vec(), 64'h0);
    xrst = 1'b1;
    @(posedge clk); #1;

    // Idle valid ignored.
    cyc(0, 1, 16'sd55);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_ov",   64'(bus.out_valid), 64'd0);

    // Basic frame.
    cyc(1, 1, 16'sd5);
    chk("basic_busy", 64'(bus.busy), 64'd1);
    cyc(0, 1, -16'sd3);
    cyc(0, 1, 16'sd7);
    chk("basic_ov_early", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 16'sd100);
    chk("basic_ov",   64'(bus.out_valid), 64'd1);
    chk("basic_data", vec(), 64'h0064_0007_FFFD_0005);
    chk("basic_idle", 64'(bus.busy), 64'd0);
    cyc(0, 0, 16'sd0);
    chk("basic_pulse", 64'(bus.out_valid), 64'd0);
    chk("basic_hold",  vec(), 64'h0064_0007_FFFD_0005);

    // Gapped frame.
    cyc(1, 1, 16'sd5);
    cyc(0, 0, 16'sd0);
    chk("gap_busy1", 64'(bus.busy), 64'd1);
    cyc(0, 1, -16'sd3);
    cyc(0, 0, 16'sd0);
    chk("gap_busy2", 64'(bus.busy), 64'd1);
    cyc(0, 1, 16'sd7);
    cyc(0, 0, 16'sd0);
    chk("gap_busy3", 64'(bus.busy), 64'd1);
    chk("gap_ov_early", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 16'sd100);
    chk("gap_ov",   64'(bus.out_valid), 64'd1);
    chk("gap_data", vec(), 64'h0064_0007_FFFD_0005);

    // Abort then restart.
    cyc(1, 1, 16'sd1);
    cyc(0, 1, 16'sd2);
    cyc(1, 1, 16'sd9);
    chk("abort_ov0", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 16'sd8);
    cyc(0, 1, 16'sd7);
    chk("abort_ov1", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 16'sd6);
    chk("abort_ov",   64'(bus.out_valid), 64'd1);
    chk("abort_data", vec(), 64'h0006_0007_0008_0009);

    // Start on what would have been the completing accept.
    cyc(1, 1, 16'sd1);
    cyc(0, 1, 16'sd2);
    cyc(0, 1, 16'sd3);
    cyc(1, 1, 16'sd4);
    chk("startwin_ov",   64'(bus.out_valid), 64'd0);
    chk("startwin_busy", 64'(bus.busy), 64'd1);
    chk("startwin_hold", vec(), 64'h0006_0007_0008_0009);
    cyc(0, 1, 16'sd5);
    cyc(0, 1, 16'sd6);
    cyc(0, 1, 16'sd7);
    chk("startwin_ov2",  64'(bus.out_valid), 64'd1);
    chk("startwin_data", vec(), 64'h0007_0006_0005_0004);

    // Back-to-back: start coincides with out_valid.
    cyc(1, 1, 16'sd10);
    chk("b2b_ov_a0", 64'(bus.out_valid), 64'd0);
    cyc(0, 1, 16'sd20);
    cyc(0, 1, 16'sd30);
    cyc(0, 1, 16'sd40);
    chk("b2b_ov_a",   64'(bus.out_valid), 64'd1);
    chk("b2b_data_a", vec(), 64'h0028_001E_0014_000A);
    cyc(1, 1, -16'sd1);
    chk("b2b_ov_b0",  64'(bus.out_valid), 64'd0);
    chk("b2b_busy_b", 64'(bus.busy), 64'd1);
    cyc(0, 1, -16'sd2);
    chk("b2b_ov_b1",  64'(bus.out_valid), 64'd0);
    cyc(0, 1, -16'sd3);
    chk("b2b_ov_b2",  64'(bus.out_valid), 64'd0);
    cyc(0, 1, -16'sd4);
    chk("b2b_ov_b",   64'(bus.out_valid), 64'd1);
    chk("b2b_data_b", vec(), 64'hFFFC_FFFD_FFFE_FFFF);

    // Flush after two samples.
    cyc(1, 1, 16'sd11);
    cyc(0, 1, 16'sd22);
    cyc(0, 0, 16'sd0, 1'b1);
`ifdef DESERIAL_FLUSH_EN
    chk("flush_ov",   64'(bus.out_valid), 64'd1);
    chk("flush_data", vec(), 64'h0000_0000_0016_000B);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    cyc(0, 0, 16'sd0, 1'b1);
    chk("flush_idle_ov", 64'(bus.out_valid), 64'd0);
`else
    chk("noflush_ov",   64'(bus.out_valid), 64'd0);
    chk("noflush_busy", 64'(bus.busy), 64'd1);
    chk("noflush_data", vec(), 64'hFFFC_FFFD_FFFE_FFFF);
`endif

    // Reset mid-frame.
    cyc(1, 1, 16'sd3);
    cyc(0, 1, 16'sd4);
    bus.in_valid = 1'b0;
    bus.deserial_start = 1'b0;
    #2;
    xrst = 1'b0;
    #1;
    chk("rst_data", vec(), 64'h0);
    chk("rst_ov",   64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    xrst = 1'b1;
    cyc(0, 1, 16'sd5);
    cyc(0, 1, 16'sd6);
    chk("rst_after_ov",   64'(bus.out_valid), 64'd0);
    chk("rst_after_data", vec(), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/deserial_vec.md
# deserial_vec

Serial-to-parallel collector for the gobou datapath. It accepts one signed DWIDTH sample per valid cycle and assembles CORE samples into a parallel vector. The vector is presented with a one-cycle completion pulse. It is the receiving end of the serial lane driven by `serial_vec`: lane 0 arrives first and is stored at index 0, so a serialize-then-deserialize round trip reproduces the original vector.

## Interface
Parameters (globals from `gobou/gobou.svh`):
- `CORE`, from svh: number of lanes in the vector.
- `DWIDTH`, from svh: sample width, signed.
- `LWIDTH`, from svh: counter width; must satisfy 2^LWIDTH > CORE.

Ports:
- `clk` in 1: clock.
- `xrst` in 1: reset, asynchronous, active-low.
- `deserial_start` in 1: begins a new frame; aborts any partial frame.
- `in_valid` in 1: `in_data` carries a sample this cycle.
- `in_data` in signed DWIDTH: serial sample.
- `flush` in 1: terminates a partial frame early. Only active when `DESERIAL_FLUSH_EN` is defined.
- `out_data` out signed DWIDTH [CORE-1:0]: last completed vector.
- `out_valid` out 1: one-cycle pulse when `out_data` is updated.
- `busy` out 1: high while in FILL.

## Operation
- Internal state:
  - FSM with states IDLE and FILL.
  - Lane counter `r_cnt` (LWIDTH bits).
  - Fill buffer `r_buf[CORE]`.
  - Output register `r_out[CORE]`, which drives `out_data`.
- IDLE:
  - `in_valid` without `deserial_start` is ignored and no state changes.
  - `deserial_start`: go to FILL, set `r_cnt`=0, clear `r_buf` to 0.
  - If `in_valid` is also high in that cycle, the sample is accepted as lane 0 and `r_cnt`=1.
- FILL:
  - Each `in_valid` cycle writes `r_buf[r_cnt]` and increments `r_cnt`.
  - Cycles without `in_valid` hold state; there is no timeout.
- Completion (accept with `r_cnt`==CORE-1):
  - `r_out` takes `r_buf` with the final lane merged in.
  - `out_valid` pulses.
  - FSM returns to IDLE and `r_cnt`=0.
- `deserial_start` during FILL:
  - The partial frame is discarded, with no `out_valid`.
  - The frame restarts exactly as from IDLE, including the same-cycle lane-0 accept.
  - If start coincides with what would be the completing accept, start wins and no output is produced.
- `r_out` holds its value until the next completion. `busy`=1 iff state is FILL.

## Timing
- Reset values: state IDLE, `r_cnt`=0, `r_buf`=0, `r_out`=0 (so `out_data` is all zero), `out_valid`=0, `busy`=0.
- Latency: `out_valid` and the new `out_data` appear on the cycle after the CORE-th accepted sample, with both registered.
- Throughput: back-to-back frames are supported. `deserial_start` may be asserted in the same cycle as `out_valid`, giving a minimum frame period of CORE cycles.
- Pairing: driving `deserial_start` one cycle after `serial_vec`'s `serial_we`, with `in_valid` high for CORE cycles, captures the full vector.
- Reset asserted mid-frame returns all state to reset values asynchronously. No `out_valid` is produced for the aborted frame.

## Configuration
- Macro: `DESERIAL_FLUSH_EN`.
- Defined:
  - `flush` high in FILL: `r_out` takes `r_buf`; unfilled lanes are 0; `out_valid` pulses next cycle; return to IDLE.
  - `flush` with a simultaneous `in_valid`: the sample is included before the flush.
  - `flush` in IDLE is ignored.
  - `deserial_start` has priority over `flush`.
- Not defined: `flush` is ignored entirely and the port is left unconnected internally.

## Test plan
All cases use CORE=4, DWIDTH=16.
- Basic frame: start+valid with samples 5, -3, 7, 100 on consecutive cycles -> one cycle later `out_valid`=1 and `out_data`={100,7,-3,5} (index 3..0). `out_data` then holds.
- Gapped input: same samples with `in_valid` low between each -> identical result; `out_valid` appears one cycle after the 4th valid; `busy` is high throughout.
- Abort: start, samples 1, 2, then start with samples 9, 8, 7, 6 -> one `out_valid` only, with `out_data`={6,7,8,9}.
- Back-to-back and reset:
  - Two frames with start coincident with `out_valid` -> two pulses 4 cycles apart, each with correct data.
  - `xrst` asserted after 2 samples -> `out_data`=0 and no pulse.
- Flush (`DESERIAL_FLUSH_EN` defined): start, samples 11, 22, then flush -> `out_data`={0,0,22,11} and `out_valid`=1. Without the macro, the same stimulus gives no pulse and `busy` stays 1.
